// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg
// Shared constants and types for the branch predictor.
//   - prediction_status encodings (ST_*)
//   - 2-bit saturating counter values (SNT/WNT/WT/ST)
//   - entry_type_t : kind of control-flow instruction held in a BTB entry
// ---------------------------------------------------------------------------
package bp_pkg;

    // prediction_status encodings
    localparam logic [1:0] ST_MISS_NT = 2'd0;  // predicted not-taken, was taken
    localparam logic [1:0] ST_MISS_T  = 2'd1;  // predicted taken, was not taken
    localparam logic [1:0] ST_OK      = 2'd2;  // prediction correct
    localparam logic [1:0] ST_NONE    = 2'd3;  // no valid branch in EX

    // 2-bit counter values
    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    typedef enum logic {
        ET_BRANCH = 1'b0,
        ET_JAL    = 1'b1
    } entry_type_t;

endpackage

// File: rtl/sat_ctr2.sv
// ---------------------------------------------------------------------------
// sat_ctr2
// Next-state logic of a 2-bit saturating up/down counter (purely
// combinational).
//   ctr      in  2  current counter value
//   taken    in  1  1 = count up, 0 = count down
//   ctr_next out 2  next value, clamped to SNT..ST (no wrap)
// ---------------------------------------------------------------------------
module sat_ctr2
    import bp_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != ST) begin
                ctr_next = ctr + 2'd1;
            end
        end else begin
            if (ctr != SNT) begin
                ctr_next = ctr - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
// Direct-mapped BTB with a 2-bit saturating counter per entry. Lookup is
// combinational on IF_pc; update happens at posedge from EX resolution.
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   IF_pc                       fetch PC for lookup
//   IF_BTBhit/IF_Branch/IF_Jump lookup hit and type of hit entry
//   IF_branch_prediction        counter of indexed entry (hit or miss)
//   IF_pc_imm                   target of hit entry (0 on miss)
//   EX_*                        resolved branch/jump from EX
//   prediction_status           combinational misprediction status
//   stat_branches/mispredicts   (only with BP_STATS_EN) event counters
//
// Optional build macro: BP_STATS_EN adds the two statistics counters.
// ---------------------------------------------------------------------------
module branch_predictor
    import bp_pkg::*;
#(
    parameter  int ENTRIES = 64,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] IF_pc,
    output logic        IF_BTBhit,
    output logic        IF_Branch,
    output logic        IF_Jump,
    output logic [1:0]  IF_branch_prediction,
    output logic [31:0] IF_pc_imm,
    input  logic        EX_valid,
    input  logic        EX_stall,
    input  logic        EX_Branch,
    input  logic        EX_Jump,
    input  logic        EX_ALUSrc,
    input  logic        EX_taken,
    input  logic [31:0] EX_pc,
    input  logic [31:0] EX_pc_imm,
    input  logic [1:0]  EX_branch_prediction,
`ifdef BP_STATS_EN
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts,
`endif
    output logic [1:0]  prediction_status
);

    localparam int TAG_W = 32 - IDX_W - 2;

    // Entry storage. Only valid and ctr need reset; tag/type/target are
    // don't-care until valid is set, so they live in a non-reset block.
    logic [ENTRIES-1:0] valid_reg;
    logic [1:0]         ctr_reg    [ENTRIES];
    logic [TAG_W-1:0]   tag_reg    [ENTRIES];
    entry_type_t        type_reg   [ENTRIES];
    logic [31:0]        target_reg [ENTRIES];

    logic [IDX_W-1:0]   if_idx;
    logic [TAG_W-1:0]   if_tag;
    logic [IDX_W-1:0]   ex_idx;
    logic [TAG_W-1:0]   ex_tag;

    logic               if_hit;
    logic               ex_hit;
    logic               upd;
    logic [1:0]         ctr_sat;
    logic [1:0]         ctr_next;

    // Byte-offset bits never participate in indexing or tagging.
    logic               unused_pc_bits;
    assign unused_pc_bits = ^{IF_pc[1:0], EX_pc[1:0]};

    assign if_idx = IF_pc[IDX_W+1:2];
    assign if_tag = IF_pc[31:IDX_W+2];
    assign ex_idx = EX_pc[IDX_W+1:2];
    assign ex_tag = EX_pc[31:IDX_W+2];

    // ---------------- lookup ----------------
    assign if_hit               = valid_reg[if_idx] && (tag_reg[if_idx] == if_tag);
    assign IF_BTBhit            = if_hit;
    assign IF_Branch            = if_hit && (type_reg[if_idx] == ET_BRANCH);
    assign IF_Jump              = if_hit && (type_reg[if_idx] == ET_JAL);
    assign IF_pc_imm            = if_hit ? target_reg[if_idx] : 32'd0;
    assign IF_branch_prediction = ctr_reg[if_idx];

    // ---------------- status ----------------
    always_comb begin
        prediction_status = ST_NONE;
        if (EX_valid && EX_Branch) begin
            if (EX_taken && (EX_branch_prediction < 2'd2)) begin
                prediction_status = ST_MISS_NT;
            end else if (!EX_taken && (EX_branch_prediction >= 2'd2)) begin
                prediction_status = ST_MISS_T;
            end else begin
                prediction_status = ST_OK;
            end
        end
    end

    // ---------------- update ----------------
    // JALR targets are register-dependent, so they are never allocated.
    assign upd = EX_valid && !EX_stall && (EX_Branch || (EX_Jump && !EX_ALUSrc));

    // A branch only trains an existing entry if that entry already holds this
    // branch; a JAL entry with the same tag is replaced as a fresh branch.
    assign ex_hit = valid_reg[ex_idx] && (tag_reg[ex_idx] == ex_tag)
                    && (type_reg[ex_idx] == ET_BRANCH);

    sat_ctr2 u_sat_ctr2 (
        .ctr      (ctr_reg[ex_idx]),
        .taken    (EX_taken),
        .ctr_next (ctr_sat)
    );

    always_comb begin
        ctr_next = ctr_reg[ex_idx];
        if (EX_Branch) begin
            if (ex_hit) begin
                ctr_next = ctr_sat;
            end else begin
                ctr_next = EX_taken ? WT : WNT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_reg[i] <= WNT;
            end
        end else if (upd) begin
            valid_reg[ex_idx] <= 1'b1;
            ctr_reg[ex_idx]   <= ctr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (upd) begin
            tag_reg[ex_idx]    <= ex_tag;
            type_reg[ex_idx]   <= EX_Branch ? ET_BRANCH : ET_JAL;
            target_reg[ex_idx] <= EX_pc_imm;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] stat_branches_reg;
    logic [31:0] stat_mispredicts_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches_reg    <= 32'd0;
            stat_mispredicts_reg <= 32'd0;
        end else if (upd && EX_Branch) begin
            stat_branches_reg <= stat_branches_reg + 32'd1;
            if ((prediction_status == ST_MISS_NT) || (prediction_status == ST_MISS_T)) begin
                stat_mispredicts_reg <= stat_mispredicts_reg + 32'd1;
            end
        end
    end

    assign stat_branches    = stat_branches_reg;
    assign stat_mispredicts = stat_mispredicts_reg;
`endif

endmodule
